level_classifier_scheduler: RTL and testbench

- Shares one level_classifier instance between NUM_REQ requesters, e.g. the parallel RDOQ candidate-level evaluators of the CABAC rate estimator.
- Arbitrates round-robin and issues the classifier start pulse with stable operands.
- Waits for done, with a timeout guard.
- Returns level_case/symbol, tagged with the requester id, through a valid/ready response port.

---
 rtl/level_classifier_scheduler_pkg.sv | 21 ++
 rtl/level_classifier_scheduler_rr_arbiter.sv | 29 ++
 rtl/level_classifier_scheduler.sv | 101 ++++++++++
 tb/tb_level_classifier_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/level_classifier_scheduler_pkg.sv
// level_classifier_scheduler_pkg: shared types and widths for the RDOQ rate-estimator schedulers.
// Holds the level-case encoding, operand/result widths and the scheduler FSM state type.
package rdoq_rate_pkg;
    localparam int ABS_LEVEL_W  = 16;
    localparam int BASE_LEVEL_W = 8;
    localparam int SYMBOL_W     = 16;

    typedef enum logic [1:0] {
        ZERO     = 2'd0,
        ONE      = 2'd1,
        TWO      = 2'd2,
        BASEPLUS = 2'd3
    } level_case_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_e;
endpackage

// File: rtl/level_classifier_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or above ptr, wrapping.
// Ports: req (request vector), ptr (search start index), grant (one-hot), idx (grant index), any (some request set).
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end
endmodule

// File: rtl/level_classifier_scheduler.sv
// level_classifier_scheduler: shares one level_classifier between NUM_REQ requesters with round-robin arbitration.
// Ports: req_valid/req_ready/req_abs_level/req_base_level (requester side), resp_valid/resp_ready/resp_id/
// resp_level_case/resp_symbol/resp_err (response side), cls_start/cls_abs_level/cls_base_level/cls_level_case/
// cls_symbol/cls_done (classifier side), busy (not IDLE).
module level_classifier_scheduler
    import rdoq_rate_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int IW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int TW            = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ABS_LEVEL_W-1:0]  req_abs_level,
    input  logic [NUM_REQ*BASE_LEVEL_W-1:0] req_base_level,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [IW-1:0]                   resp_id,
    output logic [1:0]                      resp_level_case,
    output logic [SYMBOL_W-1:0]             resp_symbol,
    output logic                            resp_err,
    output logic                            cls_start,
    output logic [ABS_LEVEL_W-1:0]          cls_abs_level,
    output logic [BASE_LEVEL_W-1:0]         cls_base_level,
    input  logic [1:0]                      cls_level_case,
    input  logic [SYMBOL_W-1:0]             cls_symbol,
    input  logic                            cls_done,
    output logic                            busy
);
    sched_state_e       state;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      gid;
    logic [TW-1:0]      timer;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      idx;
    logic               any;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );

    // Grant is only offered while idle; the request is consumed on the edge that leaves IDLE.
    assign req_ready  = (state == S_IDLE) ? grant : '0;
    assign cls_start  = state == S_ISSUE;
    assign resp_valid = state == S_RESP;
    assign busy       = state != S_IDLE;
    assign resp_id    = gid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            rr_ptr          <= '0;
            gid             <= '0;
            timer           <= '0;
            cls_abs_level   <= '0;
            cls_base_level  <= '0;
            resp_level_case <= '0;
            resp_symbol     <= '0;
            resp_err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (any) begin
                    gid            <= idx;
                    cls_abs_level  <= req_abs_level[idx*ABS_LEVEL_W +: ABS_LEVEL_W];
                    cls_base_level <= req_base_level[idx*BASE_LEVEL_W +: BASE_LEVEL_W];
                    state          <= S_ISSUE;
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: if (cls_done) begin
                    // Done takes priority over a coincident timer expiry.
                    resp_level_case <= cls_level_case;
                    resp_symbol     <= cls_symbol;
                    resp_err        <= 1'b0;
                    state           <= S_RESP;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    resp_level_case <= ZERO;
                    resp_symbol     <= '0;
                    resp_err        <= 1'b1;
                    state           <= S_RESP;
                end else begin
                    timer <= timer + 1'b1;
                end
                S_RESP: if (resp_ready) begin
                    rr_ptr <= (gid == IW'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_level_classifier_scheduler.sv
// tb_level_classifier_scheduler: scoreboard bench with a registered classifier model for level_classifier_scheduler.
module tb_level_classifier_scheduler;
    localparam int N  = 4;
    localparam int TO = 16;

    typedef struct {
        int id;
        int lc;
        int sym;
        int err;
    } exp_t;

    logic          clk = 0;
    logic          rst = 1;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*16-1:0] req_abs_level = '0;
    logic [N*8-1:0]  req_base_level = '0;
    logic          resp_valid;
    logic          resp_ready = 1;
    logic [1:0]    resp_id;
    logic [1:0]    resp_level_case;
    logic [15:0]   resp_symbol;
    logic          resp_err;
    logic          cls_start;
    logic [15:0]   cls_abs_level;
    logic [7:0]    cls_base_level;
    logic [1:0]    cls_level_case = '0;
    logic [15:0]   cls_symbol = '0;
    logic          cls_done = 0;
    logic          busy;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   rv_cnt = 0;
    int   grant_cyc = 0;
    int   start_cyc = 0;
    int   rv_cyc = 0;
    int   done_delay = 1;
    int   cnt = 0;
    logic stray = 0;
    logic prev_rv = 0;
    exp_t sb[$];
    int   grant_log[$];

    level_classifier_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_abs_level(req_abs_level), .req_base_level(req_base_level),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_level_case(resp_level_case), .resp_symbol(resp_symbol), .resp_err(resp_err),
        .cls_start(cls_start), .cls_abs_level(cls_abs_level), .cls_base_level(cls_base_level),
        .cls_level_case(cls_level_case), .cls_symbol(cls_symbol), .cls_done(cls_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int cls_lc(input int abs_l);
        return abs_l >= 3 ? 3 : abs_l;
    endfunction

    function automatic int cls_sym(input int abs_l, input int base_l);
        return abs_l >= base_l ? abs_l - base_l : abs_l;
    endfunction

    // Registered classifier: done arrives done_delay cycles after the start cycle; 0 means never.
    always @(posedge clk) begin
        if (rst) begin
            cnt      <= 0;
            cls_done <= 0;
        end else begin
            cls_done <= stray;
            if (cls_start) begin
                cls_level_case <= 2'(cls_lc(int'(cls_abs_level)));
                cls_symbol     <= 16'(cls_sym(int'(cls_abs_level), int'(cls_base_level)));
                if (done_delay == 1) cls_done <= 1;
                cnt <= done_delay > 1 ? done_delay - 1 : 0;
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) cls_done <= 1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (req_ready != '0) begin
                exp_t e;
                int a;
                int b;
                chk("grant_onehot", 32'($onehot(req_ready)), 1);
                chk("grant_idle", 32'(busy), 0);
                e.id = 0;
                for (int k = 0; k < N; k++) if (req_ready[k]) e.id = k;
                a = int'(req_abs_level[e.id*16 +: 16]);
                b = int'(req_base_level[e.id*8 +: 8]);
                e.err = (done_delay == 0 || done_delay > TO) ? 1 : 0;
                e.lc  = e.err ? 0 : cls_lc(a);
                e.sym = e.err ? 0 : cls_sym(a, b);
                sb.push_back(e);
                grant_log.push_back(e.id);
                grant_cyc = cyc;
            end
            if (cls_start) start_cyc = cyc;
            if (resp_valid && !prev_rv) begin
                rv_cyc = cyc;
                rv_cnt++;
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) chk("sb_empty", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_id", 32'(resp_id), e.id);
                    chk("resp_case", 32'(resp_level_case), e.lc);
                    chk("resp_sym", 32'(resp_symbol), e.sym);
                    chk("resp_err", 32'(resp_err), e.err);
                end
                hs_cnt++;
            end
            prev_rv = resp_valid;
        end else prev_rv = 0;
    end

    task automatic set_op(input int id, input int a, input int b);
        req_abs_level[id*16 +: 16] = 16'(a);
        req_base_level[id*8 +: 8]  = 8'(b);
    endtask

    task automatic wait_grants(input int n);
        int t = 0;
        while (grant_log.size() < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (grant_log.size() < n) chk("grant_timeout", 32'(grant_log.size()), 32'(n));
    endtask

    task automatic wait_hs(input int n);
        int t = 0;
        while (hs_cnt < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("hs_reached", 32'(hs_cnt >= n), 1);
    endtask

    task automatic single(input int id);
        int g;
        int h;
        g = grant_log.size();
        h = hs_cnt;
        @(posedge clk) #1 req_valid = 4'(1 << id);
        wait_grants(g + 1);
        @(posedge clk) #1 req_valid = '0;
        wait_hs(h + 1);
    endtask

    task automatic chk_zero_outputs();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_id", 32'(resp_id), 0);
        chk("rst_resp_case", 32'(resp_level_case), 0);
        chk("rst_resp_sym", 32'(resp_symbol), 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        chk("rst_cls_start", 32'(cls_start), 0);
        chk("rst_cls_abs", 32'(cls_abs_level), 0);
        chk("rst_cls_base", 32'(cls_base_level), 0);
        chk("rst_busy", 32'(busy), 0);
    endtask

    initial begin
        logic [31:0] pay;
        int h;
        int r;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk_zero_outputs();

        // Round-robin from pointer 0 with all requesters asserted.
        for (int k = 0; k < N; k++) set_op(k, k == 3 ? 7 : k, 3);
        grant_log.delete();
        @(posedge clk) #1 req_valid = '1;
        wait_grants(5);
        @(posedge clk) #1 req_valid = '0;
        wait_hs(5);
        for (int k = 0; k < 5; k++) chk("rr_order", 32'(grant_log[k]), 32'(k % N));

        // Single request latency: start one cycle, resp three cycles after accept.
        set_op(0, 7, 3);
        single(0);
        chk("lat_start", 32'(start_cyc - grant_cyc), 1);
        chk("lat_resp", 32'(rv_cyc - grant_cyc), 3);

        // Backpressure: payload stable, no grants while response stalls.
        set_op(1, 2, 3);
        set_op(2, 9, 2);
        h = hs_cnt;
        @(posedge clk) #1 begin
            resp_ready = 0;
            req_valid  = 4'b0110;
        end
        r = 0;
        while (!resp_valid && r < 40) begin
            @(negedge clk);
            r++;
        end
        chk("bp_valid", 32'(resp_valid), 1);
        pay = {resp_id, resp_level_case, resp_symbol, resp_err, 11'd0};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid_hold", 32'(resp_valid), 1);
            chk("bp_payload", {resp_id, resp_level_case, resp_symbol, resp_err, 11'd0}, pay);
            chk("bp_no_ready", 32'(req_ready), 0);
        end
        @(posedge clk) #1 begin
            req_valid  = '0;
            resp_ready = 1;
        end
        repeat (4) @(negedge clk);
        chk("bp_one_hs", 32'(hs_cnt), 32'(h + 1));

        // Timeout: no done ever; 16 waiting cycles then an error response.
        done_delay = 0;
        set_op(2, 5, 3);
        single(2);
        chk("to_wait", 32'(rv_cyc - start_cyc - 1), TO);
        done_delay = 1;
        set_op(3, 1, 3);
        single(3);

        // Done on the last timeout cycle wins.
        done_delay = TO;
        set_op(1, 7, 2);
        single(1);
        chk("race_wait", 32'(rv_cyc - start_cyc - 1), TO);
        done_delay = 1;

        // Stray done while idle produces nothing.
        r = rv_cnt;
        h = hs_cnt;
        @(posedge clk) #1 stray = 1;
        @(posedge clk) #1 stray = 0;
        repeat (6) @(negedge clk);
        chk("stray_no_resp", 32'(rv_cnt), 32'(r));
        chk("stray_no_hs", 32'(hs_cnt), 32'(h));

        // Reset during WAIT drops the request and clears the pointer.
        done_delay = 0;
        set_op(2, 4, 3);
        r = grant_log.size();
        @(posedge clk) #1 req_valid = 4'b0100;
        wait_grants(r + 1);
        @(posedge clk) #1 req_valid = '0;
        repeat (4) @(posedge clk);
        #1 rst = 1;
        sb.delete();
        @(posedge clk) #1 rst = 0;
        @(negedge clk);
        chk_zero_outputs();
        r = rv_cnt;
        repeat (20) @(negedge clk);
        chk("rst_dropped", 32'(rv_cnt), 32'(r));
        done_delay = 1;
        for (int k = 0; k < N; k++) set_op(k, k + 1, 1);
        grant_log.delete();
        h = hs_cnt;
        @(posedge clk) #1 req_valid = '1;
        wait_grants(1);
        @(posedge clk) #1 req_valid = '0;
        wait_hs(h + 1);
        chk("rst_ptr_first", 32'(grant_log[0]), 0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
